cmp_result_monitor: RTL and testbench

Receiving end of the comparator's three one-hot result lines (LT/EQ/GT, the signals that drive LED1/LED2/LED3). On a sample request it waits for the lines to hold stable, decodes them into a 2-bit result code, and keeps saturating tallies per outcome. With the error feature compiled in, it also flags and counts illegal (non-one-hot) patterns. It sits between the comparator and the board's display/readback logic.

---
 rtl/cmp_result_monitor.sv | 172 +++++++++++++++++
 tb/tb_cmp_result_monitor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_result_monitor.sv
// rtl/cmp_result_monitor.sv - debounced capture and tally of the comparator LT/EQ/GT result lines
// Optional macro CMP_MON_ERR_EN: flag and count non-one-hot patterns instead of priority-decoding them.
module cmp_result_monitor #(
  parameter int CNT_W       = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_lt,
  input  logic             in_eq,
  input  logic             in_gt,
  input  logic             sample,
  input  logic             clr,
  output logic             busy,
  output logic             result_valid,
  output logic [1:0]       result_code,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] snap_q, snap_d;
  logic [7:0] stab_q, stab_d;
  logic [2:0] in_vec;

  logic [1:0] code_dec;
  logic       hit_lt, hit_eq, hit_gt, hit_err;
  logic       capture_en;

  logic             result_valid_q;
  logic [1:0]       result_code_q;
  logic [CNT_W-1:0] lt_cnt_q, eq_cnt_q, gt_cnt_q;

  assign in_vec = {in_lt, in_eq, in_gt};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q  <= 3'b000;
      stab_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      stab_q  <= stab_d;
    end
  end

  // Any input change while settling reloads the snapshot and restarts the hold window.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    stab_d  = stab_q;
    if (clr) begin
      state_d = S_IDLE;
      stab_d  = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sample) begin
            snap_d  = in_vec;
            stab_d  = 8'd0;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (in_vec == snap_q) begin
            if (stab_q == HOLD_LAST) state_d = S_CAPTURE;
            else                     stab_d  = stab_q + 8'd1;
          end else begin
            snap_d = in_vec;
            stab_d = 8'd0;
          end
        end
        S_CAPTURE: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    capture_en = (state_q == S_CAPTURE) && !clr;
  end

  always_comb begin
    code_dec = 2'b00;
    hit_lt   = 1'b0;
    hit_eq   = 1'b0;
    hit_gt   = 1'b0;
    hit_err  = 1'b0;
`ifdef CMP_MON_ERR_EN
    case (snap_q)
      3'b100:  begin code_dec = 2'b01; hit_lt = 1'b1; end
      3'b010:  begin code_dec = 2'b10; hit_eq = 1'b1; end
      3'b001:  begin code_dec = 2'b11; hit_gt = 1'b1; end
      default: hit_err = 1'b1;
    endcase
`else
    if (snap_q[0]) begin
      code_dec = 2'b11; hit_gt = 1'b1;
    end else if (snap_q[1]) begin
      code_dec = 2'b10; hit_eq = 1'b1;
    end else if (snap_q[2]) begin
      code_dec = 2'b01; hit_lt = 1'b1;
    end
`endif
  end

  // result_code survives clr; only rst or a new capture changes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_valid_q <= 1'b0;
      result_code_q  <= 2'b00;
    end else begin
      result_valid_q <= capture_en;
      if (capture_en) result_code_q <= code_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      lt_cnt_q <= '0;
      eq_cnt_q <= '0;
      gt_cnt_q <= '0;
    end else if (capture_en) begin
      if (hit_lt) lt_cnt_q <= sat_inc(lt_cnt_q);
      if (hit_eq) eq_cnt_q <= sat_inc(eq_cnt_q);
      if (hit_gt) gt_cnt_q <= sat_inc(gt_cnt_q);
    end
  end

`ifdef CMP_MON_ERR_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (capture_en && hit_err) begin
      err_cnt_q <= sat_inc(err_cnt_q);
      err_q     <= 1'b1;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err     = err_q;
`else
  logic unused_err;
  assign unused_err = hit_err;
  assign err_cnt    = '0;
  assign err        = 1'b0;
`endif

  assign result_valid = result_valid_q;
  assign result_code  = result_code_q;
  assign lt_cnt       = lt_cnt_q;
  assign eq_cnt       = eq_cnt_q;
  assign gt_cnt       = gt_cnt_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// tb/tb_cmp_result_monitor.sv - scoreboard bench for cmp_result_monitor
module tb_cmp_result_monitor;

  localparam int CNT_W = 2;
  localparam int HOLD  = 4;

`ifdef CMP_MON_ERR_EN
  localparam logic [1:0] ILL_CODE = 2'b00;
  localparam int         EQ_ILL   = 1;
  localparam int         EC_ILL   = 1;
  localparam int         EC_ZERO  = 2;
  localparam logic       E_ILL    = 1'b1;
`else
  localparam logic [1:0] ILL_CODE = 2'b10;
  localparam int         EQ_ILL   = 2;
  localparam int         EC_ILL   = 0;
  localparam int         EC_ZERO  = 0;
  localparam logic       E_ILL    = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_lt = 1'b0, in_eq = 1'b0, in_gt = 1'b0;
  logic sample = 1'b0, clr = 1'b0;
  logic busy, result_valid, err;
  logic [1:0] result_code;
  logic [CNT_W-1:0] lt_cnt, eq_cnt, gt_cnt, err_cnt;

  cmp_result_monitor #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .in_lt(in_lt), .in_eq(in_eq), .in_gt(in_gt),
    .sample(sample), .clr(clr), .busy(busy), .result_valid(result_valid),
    .result_code(result_code), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt),
    .gt_cnt(gt_cnt), .err_cnt(err_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] code;
    int lt; int eq; int gt; int ec;
    logic e;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [1:0] code, input int lt, input int eq, input int gt,
                      input int ec, input logic e, input int at);
    exp_t x;
    x.code = code; x.lt = lt; x.eq = eq; x.gt = gt; x.ec = ec; x.e = e; x.at = at;
    sb.push_back(x);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic [2:0] v);
    {in_lt, in_eq, in_gt} = v;
  endtask

  task automatic check_idle_zero(input string tag, input logic [1:0] held_code);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rv"},   32'(result_valid), 32'd0);
    chk({tag, "_code"}, 32'(result_code), 32'(held_code));
    chk({tag, "_lt"},   32'(lt_cnt), 32'd0);
    chk({tag, "_eq"},   32'(eq_cnt), 32'd0);
    chk({tag, "_gt"},   32'(gt_cnt), 32'd0);
    chk({tag, "_ec"},   32'(err_cnt), 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
  endtask

  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("cap_cycle", 32'(cyc), 32'(mon_e.at));
        chk("cap_code",  32'(result_code), 32'(mon_e.code));
        chk("cap_lt",    32'(lt_cnt), 32'(mon_e.lt));
        chk("cap_eq",    32'(eq_cnt), 32'(mon_e.eq));
        chk("cap_gt",    32'(gt_cnt), 32'(mon_e.gt));
        chk("cap_ec",    32'(err_cnt), 32'(mon_e.ec));
        chk("cap_err",   32'(err), 32'(mon_e.e));
      end
    end
  end

  int c0;

  initial begin
    tick(2);
    rst = 1'b0;
    check_idle_zero("reset", 2'b00);

    // basic LT capture with busy window
    set_in(3'b100);
    c0 = cyc; sample = 1'b1;
    push(2'b01, 1, 0, 0, 0, 1'b0, c0 + HOLD + 2);
    tick(); sample = 1'b0;
    chk("lt_busy_first", 32'(busy), 32'd1);
    tick(HOLD);
    chk("lt_busy_last", 32'(busy), 32'd1);
    tick();
    chk("lt_busy_done", 32'(busy), 32'd0);
    tick(3);

    // bounce: 010, one-cycle 001 glitch in cycle 2, back to 010
    set_in(3'b010);
    c0 = cyc; sample = 1'b1;
    push(2'b10, 1, 1, 0, 0, 1'b0, c0 + 9);
    tick(); sample = 1'b0;
    tick(); set_in(3'b001);
    tick(); set_in(3'b010);
    tick(9);

    // illegal 110
    set_in(3'b110);
    c0 = cyc; sample = 1'b1;
    push(ILL_CODE, 1, EQ_ILL, 0, EC_ILL, E_ILL, c0 + 6);
    tick(); sample = 1'b0;
    tick(8);

    // all-zero pattern
    set_in(3'b000);
    c0 = cyc; sample = 1'b1;
    push(2'b00, 1, EQ_ILL, 0, EC_ZERO, E_ILL, c0 + 6);
    tick(); sample = 1'b0;
    tick(8);

    // sample held high with stable GT: back-to-back captures, saturation at 3
    set_in(3'b001);
    c0 = cyc; sample = 1'b1;
    push(2'b11, 1, EQ_ILL, 1, EC_ZERO, E_ILL, c0 + 6);
    push(2'b11, 1, EQ_ILL, 2, EC_ZERO, E_ILL, c0 + 12);
    push(2'b11, 1, EQ_ILL, 3, EC_ZERO, E_ILL, c0 + 18);
    push(2'b11, 1, EQ_ILL, 3, EC_ZERO, E_ILL, c0 + 24);
    push(2'b11, 1, EQ_ILL, 3, EC_ZERO, E_ILL, c0 + 30);
    tick(25); sample = 1'b0;
    tick(10);
    chk("sat_sb_drained", 32'(sb.size()), 32'd0);

    // clr during SETTLE aborts with no result and clears counters
    set_in(3'b100);
    sample = 1'b1;
    tick(); sample = 1'b0;
    tick(2); clr = 1'b1;
    tick(); clr = 1'b0;
    check_idle_zero("clr_settle", 2'b11);
    tick(8);
    chk("clr_settle_idle", 32'(busy), 32'd0);

    // fresh LT capture after clr
    c0 = cyc; sample = 1'b1;
    push(2'b01, 1, 0, 0, 0, 1'b0, c0 + 6);
    tick(); sample = 1'b0;
    tick(8);

    // clr and sample together: sample dropped, code held
    set_in(3'b010);
    clr = 1'b1; sample = 1'b1;
    tick(); clr = 1'b0; sample = 1'b0;
    check_idle_zero("clr_sample", 2'b01);
    tick(7);
    chk("clr_sample_idle", 32'(busy), 32'd0);

    // recovery capture
    c0 = cyc; sample = 1'b1;
    push(2'b10, 0, 1, 0, 0, 1'b0, c0 + 6);
    tick(); sample = 1'b0;
    tick(8);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
